// File: rtl/arashi_mt_thread_cache.sv
// arashi_mt_thread_cache: per-thread FIFO channels with round-robin drain.
// One shared write port, one shared read port, registered handshakes.
module arashi_mt_thread_cache #(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 4,
  parameter  int NUM_CH     = 4,
  localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  w_ena,
  input  logic [CHW-1:0]        w_ch,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  w_ready,
  output logic                  w_drop,
  output logic [NUM_CH-1:0]     full,
  input  logic                  r_ena,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  r_valid,
  output logic [CHW-1:0]        r_ch,
  output logic                  avail
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         w_ptr [NUM_CH];
  logic [PW-1:0]         r_ptr [NUM_CH];
  logic [PW-1:0]         occ   [NUM_CH];
  logic [DATA_WIDTH-1:0] mem   [NUM_CH][DEPTH];
  logic [CHW-1:0]        last_grant;
  logic [CHW-1:0]        gnt_ch;
  logic                  found;
  logic                  w_ok;
  logic                  w_acc;
  logic                  rd_gnt;
  int                    idx;
  int                    total;

  always_comb begin
    total = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      occ[i]  = w_ptr[i] - r_ptr[i];
      full[i] = (occ[i] == PW'(DEPTH));
      total   = total + int'(occ[i]);
    end
  end

  // Out-of-range channels never match, so they are rejected.
  always_comb begin
    w_ok = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ch == CHW'(i)) w_ok = !full[i];
    end
  end

  assign w_acc = rstn & w_ena & w_ok;

  always_comb begin
    gnt_ch = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_grant) + k) % NUM_CH;
      if (!found && occ[idx] != '0) begin
        found  = 1'b1;
        gnt_ch = CHW'(idx);
      end
    end
  end

  assign rd_gnt = rstn & r_ena & found;
  assign avail  = (total + int'(w_acc)) > int'(rd_gnt);

  always_ff @(posedge clk) begin
    if (w_acc) mem[w_ch][w_ptr[w_ch][AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        w_ptr[i] <= '0;
        r_ptr[i] <= '0;
      end
      last_grant <= CHW'(NUM_CH - 1);
      w_ready    <= 1'b0;
      w_drop     <= 1'b0;
      r_valid    <= 1'b0;
      r_ch       <= '0;
      data_out   <= '0;
    end else begin
      w_ready <= w_acc;
      w_drop  <= w_ena & !w_acc;
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_acc && w_ch == CHW'(i))
          w_ptr[i] <= w_ptr[i] + 1'b1;
        if (rd_gnt && gnt_ch == CHW'(i))
          r_ptr[i] <= r_ptr[i] + 1'b1;
      end
      r_valid <= rd_gnt;
      if (rd_gnt) begin
        r_ch       <= gnt_ch;
        data_out   <= mem[gnt_ch][r_ptr[gnt_ch][AW-1:0]];
        last_grant <= gnt_ch;
      end else begin
        r_ch     <= '0;
        data_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_arashi_mt_thread_cache.sv
// Scoreboard bench for arashi_mt_thread_cache.
// Behavioral per-channel queues predict every registered output.
module tb_arashi_mt_thread_cache;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       w_ena = 1'b0;
  logic [1:0] w_ch = '0;
  logic [7:0] data_in = '0;
  logic       w_ready;
  logic       w_drop;
  logic [2:0] full;
  logic       r_ena = 1'b0;
  logic [7:0] data_out;
  logic       r_valid;
  logic [1:0] r_ch;
  logic       avail;

  arashi_mt_thread_cache #(
    .DATA_WIDTH(8),
    .DEPTH(4),
    .NUM_CH(3)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .w_ena(w_ena),
    .w_ch(w_ch),
    .data_in(data_in),
    .w_ready(w_ready),
    .w_drop(w_drop),
    .full(full),
    .r_ena(r_ena),
    .data_out(data_out),
    .r_valid(r_valid),
    .r_ch(r_ch),
    .avail(avail)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       wd;
    logic       rv;
    logic [1:0] rc;
    logic [7:0] d;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mq [3][$];
  int         mlast = 2;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic we, input logic [1:0] wc,
                     input logic [7:0] d, input logic re,
                     input logic rs = 1'b1);
    exp_t e;
    exp_t o;
    logic [2:0] ef;
    int g;
    int tot;
    logic acc;
    @(negedge clk);
    rstn = rs; w_ena = we; w_ch = wc; data_in = d; r_ena = re;
    #1;
    ef = '0;
    tot = 0;
    for (int c = 0; c < 3; c++) begin
      ef[c] = (mq[c].size() == 4);
      tot += mq[c].size();
    end
    chk("full", 32'(full), 32'(ef));
    e = '{wr: 1'b0, wd: 1'b0, rv: 1'b0, rc: 2'd0, d: 8'd0};
    if (!rs) begin
      for (int c = 0; c < 3; c++) mq[c].delete();
      mlast = 2;
    end else begin
      acc = we && (wc < 2'd3) && (mq[wc].size() < 4);
      g = -1;
      if (re) begin
        for (int k = 1; k <= 3; k++) begin
          if (g < 0 && mq[(mlast + k) % 3].size() > 0)
            g = (mlast + k) % 3;
        end
      end
      chk("avail", 32'(avail),
          32'((tot + int'(acc) - int'(g >= 0)) > 0));
      e.wr = acc;
      e.wd = we && !acc;
      if (g >= 0) begin
        e.rv = 1'b1;
        e.rc = 2'(g);
        e.d  = mq[g].pop_front();
        mlast = g;
      end
      if (acc) mq[wc].push_back(d);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      o = sb.pop_front();
      chk("w_ready", 32'(w_ready), 32'(o.wr));
      chk("w_drop", 32'(w_drop), 32'(o.wd));
      chk("r_valid", 32'(r_valid), 32'(o.rv));
      chk("r_ch", 32'(r_ch), 32'(o.rc));
      chk("data_out", 32'(data_out), 32'(o.d));
    end
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_avail", 32'(avail), 32'd0);

    for (int i = 0; i < 5; i++) cyc(1, 1, 8'(8'h11 + i), 0);
    chk("fill_full", 32'(full), 32'b010);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1);
      chk("fill_rd", 32'(data_out), 32'(8'h11 + i));
    end

    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 8'hA0, 0);
    cyc(1, 0, 8'hA1, 0);
    cyc(1, 2, 8'hC0, 0);
    cyc(0, 0, 0, 1);
    chk("rr0", 32'({r_ch, data_out}), 32'({2'd0, 8'hA0}));
    cyc(0, 0, 0, 1);
    chk("rr1", 32'({r_ch, data_out}), 32'({2'd2, 8'hC0}));
    cyc(0, 0, 0, 1);
    chk("rr2", 32'({r_ch, data_out}), 32'({2'd0, 8'hA1}));
    cyc(0, 0, 0, 1);
    chk("rr_idle", 32'({r_valid, data_out}), 32'd0);

    cyc(1, 0, 8'h5A, 1);
    chk("nobyp_rv", 32'(r_valid), 32'd0);
    cyc(0, 0, 0, 1);
    chk("nobyp_pop", 32'({r_valid, data_out}), 32'({1'b1, 8'h5A}));

    for (int i = 0; i < 4; i++) cyc(1, 2, 8'(8'hC1 + i), 0);
    chk("ch2_full", 32'(full), 32'b100);
    cyc(1, 2, 8'hEE, 1);
    chk("fullpop_drop", 32'({w_drop, data_out}), 32'({1'b1, 8'hC1}));
    chk("fullpop_occ3", 32'(full), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    cyc(1, 1, 8'h77, 0);
    cyc(1, 3, 8'h99, 0);
    chk("bad_ch_drop", 32'(w_drop), 32'd1);
    cyc(0, 0, 0, 1);

    for (int i = 0; i < 3; i++) cyc(1, 0, 8'(8'h30 + i), 0);
    cyc(1, 0, 8'h3F, 1, 0);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_avail", 32'(avail), 32'd0);
    chk("mid_rst_rv", 32'(r_valid), 32'd0);
    cyc(1, 1, 8'h41, 0);
    cyc(1, 0, 8'h40, 0);
    cyc(0, 0, 0, 1);
    chk("post_rst_gnt", 32'(r_ch), 32'd0);
    cyc(0, 0, 0, 1);

    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          8'($urandom), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 49) != 0));
    end
    for (int i = 0; i < 14; i++) cyc(0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
